store_merge: RTL and testbench
==============================

STORE_MERGE -- requirements
Module: store_merge

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous to clk and active-high.
REQ-003 SHALL have ports: st_req  in  1  store request from MEM stage, sampled only in IDLE.
REQ-004 SHALL have ports: st_op  in  2  store size: 00 sb, 01 sh, 10 sw, 11 illegal.
REQ-005 SHALL have ports: st_addr  in  32  byte address.
REQ-006 SHALL have ports: st_data  in  32  store data, right-justified; upper bits beyond size ignored.
REQ-007 SHALL have ports: st_busy  out  1  pipeline stall, high whenever state != IDLE (combinational from state).
REQ-008 SHALL have ports: st_done  out  1  one-cycle pulse, store committed to memory.
REQ-009 SHALL have ports: st_err  out  1  one-cycle pulse, misaligned or illegal store.
REQ-010 SHALL have ports: mem_addr  out  32  word address, bits [1:0] always 00.
REQ-011 SHALL have ports: mem_rd  out  1  one-cycle word read strobe.
REQ-012 SHALL have ports: mem_rdata  in  32  read data, valid when mem_rvalid=1.
REQ-013 SHALL have ports: mem_rvalid  in  1  read data valid.
REQ-014 SHALL have ports: mem_wr  out  1  write request, held until accepted.
REQ-015 SHALL have ports: mem_wdata  out  32  full word to write.
REQ-016 SHALL have ports: mem_ready  in  1  write accepted in cycle where mem_wr=mem_ready=1.

Function
REQ-017 SHALL implement FSM states IDLE, READ, WAIT, WRITE.
REQ-018 IDLE + st_req + legal aligned sw SHALL capture addr/data and go to WRITE next cycle, no read.
REQ-019 IDLE + st_req + legal aligned sb/sh SHALL capture request and go to READ.
REQ-020 READ SHALL assert mem_rd for exactly one cycle with mem_addr={st_addr[31:2],2'b00}, then go to WAIT.
REQ-021 WAIT SHALL remain until mem_rvalid=1, then register merged word and go to WRITE; mem_rvalid outside WAIT ignored.
REQ-022 Merge SHALL be little-endian: byte lane k=addr[1:0] occupies bits [8k+7:8k]; sh at addr[1]=h occupies bits [16h+15:16h]; all other lanes keep mem_rdata.
REQ-023 WRITE SHALL hold mem_wr, mem_addr, mem_wdata stable until mem_ready=1; in that cycle st_done=1 and next state IDLE.
REQ-024 Misaligned (sh with addr[0]=1; sw with addr[1:0]!=00) or st_op=11 in IDLE with st_req SHALL pulse st_err next cycle, issue no memory access, stay IDLE.
REQ-025 st_req while st_busy=1 SHALL be ignored; requester holds request until st_busy falls.
REQ-026 Best-case latency: sw 1 cycle request-to-done (mem_ready=1); sb/sh 3 cycles with mem_rvalid one cycle after mem_rd and mem_ready=1.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-028 A new request SHALL be accepted in the cycle after st_done (back-to-back, no bubble beyond IDLE cycle).

Reset
REQ-029 rst=1 SHALL force IDLE and st_busy, st_done, st_err, mem_rd, mem_wr=0; mem_addr, mem_wdata=0.
REQ-030 rst mid-operation (any state) SHALL abandon captured request; no write issued after reset; late mem_rvalid/mem_ready ignored.

Structure
REQ-031 Shared package store_pkg SHALL hold st_op encodings (OP_SB, OP_SH, OP_SW) and FSM state encoding.
REQ-032 Byte/halfword merge SHALL be a combinational sub-module lane_merge (inputs old word, data, op, addr[1:0]; output merged word).

Verification
REQ-033 sw addr=0x100 data=0xDEADBEEF, mem_ready=1 -> mem_wr with mem_addr=0x100, mem_wdata=0xDEADBEEF, st_done next cycle, no mem_rd.
REQ-034 sb addr=0x203 data=0x000000AA, mem_rdata=0x11223344 -> mem_rd at 0x200, mem_wdata=0xAA223344, st_done.
REQ-035 sh addr=0x302 data=0x0000BEEF, mem_rdata=0x11223344 -> mem_wdata=0xBEEF3344; then sh addr=0x301 -> st_err pulse, no mem_rd/mem_wr.
REQ-036 sb with mem_rvalid delayed 4 cycles and mem_ready low 3 cycles -> st_busy high throughout, mem_wr/wdata stable, single st_done.
REQ-037 rst asserted in WAIT, then mem_rvalid=1 -> state IDLE, no mem_wr, no st_done.
REQ-038 Two back-to-back sw requests held under st_busy -> two writes in order, two st_done pulses, no dropped or duplicated write.

Source files
------------

// File: rtl/store_pkg.sv
// Shared encodings for the store merge block: store size codes and FSM states.
// No logic here beyond a pure legality helper used at request acceptance.
// Imported by store_merge and lane_merge.
package store_pkg;

  localparam logic [1:0] OP_SB  = 2'b00;
  localparam logic [1:0] OP_SH  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // A store is legal when the size code is defined and the address is
  // naturally aligned for that size.
  function automatic logic store_legal(input logic [1:0] op, input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_SB:   ok = 1'b1;
      OP_SH:   ok = ~addr_lo[0];
      OP_SW:   ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/store_merge_lane_merge.sv
// Little-endian byte/halfword insertion of store data into an existing word.
// Purely combinational; no state, no flow control.
// Lanes outside the store size keep the old word.
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  op,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Overwrite only the lane(s) addressed by the store, keep the rest.
  always_comb begin
    merged = old_word;
    case (op)
      OP_SB:   merged[{addr_lo, 3'b000} +: 8]      = data[7:0];
      OP_SH:   merged[{addr_lo[1], 4'b0000} +: 16] = data[15:0];
      OP_SW:   merged                              = data;
      default: merged                              = old_word;
    endcase
  end

endmodule

// File: rtl/store_merge.sv
// Store unit: sw writes directly, sb/sh do read-merge-write of the containing word.
// Latency: sw 1 cycle request-to-done, sb/sh 3 cycles best case.
// Stalls the pipeline via st_busy; mem_wr is held until mem_ready.
module store_merge
  import store_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        st_req,
  input  logic [1:0]  st_op,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_busy,
  output logic        st_done,
  output logic        st_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready
);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] merged;
  logic        accept;
  logic        legal;

  assign legal  = store_legal(st_op, st_addr[1:0]);
  assign accept = (state == S_IDLE) && st_req;

  lane_merge u_lane_merge (
    .old_word (mem_rdata),
    .data     (data_q),
    .op       (op_q),
    .addr_lo  (addr_q[1:0]),
    .merged   (merged)
  );

  // State register; reset abandons any in-flight store.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and memory strobes; rd and wr live in disjoint states.
  always_comb begin
    state_nxt = state;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    st_done   = 1'b0;
    case (state)
      S_IDLE: begin
        if (st_req && legal) state_nxt = (st_op == OP_SW) ? S_WRITE : S_READ;
      end
      S_READ: begin
        mem_rd    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_wr = 1'b1;
        if (mem_ready) begin
          st_done   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Capture the request in IDLE, register the merged word when read data lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_SB;
      addr_q  <= '0;
      data_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (legal) begin
          op_q   <= st_op;
          addr_q <= st_addr;
          data_q <= st_data;
          if (st_op == OP_SW) wdata_q <= st_data;
        end else begin
          err_q <= 1'b1;
        end
      end else if (state == S_WAIT && mem_rvalid) begin
        wdata_q <= merged;
      end
    end
  end

  assign st_busy   = (state != S_IDLE);
  assign st_err    = err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_merge.sv
// Directed bench for store_merge: sw, sb/sh merges, errors, stalls, reset, back-to-back.
// Inputs driven at negedge, outputs checked 1 time unit later.
// A negedge monitor counts strobes and logs accepted writes.
module tb_store_merge;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_req;
  logic [1:0]  st_op;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  int n_checks = 0;
  int n_errors = 0;

  int rd_cnt = 0;
  int wr_acc_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic [31:0] wlog_addr[$];
  logic [31:0] wlog_data[$];

  always #5 clk = ~clk;

  store_merge dut (
    .clk        (clk),
    .rst        (rst),
    .st_req     (st_req),
    .st_op      (st_op),
    .st_addr    (st_addr),
    .st_data    (st_data),
    .st_busy    (st_busy),
    .st_done    (st_done),
    .st_err     (st_err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready)
  );

  // Per-cycle strobe bookkeeping, sampled mid-cycle once inputs have settled.
  always @(negedge clk) begin
    #2;
    if (mem_rd) rd_cnt++;
    if (st_done) done_cnt++;
    if (mem_rd && mem_wr) overlap_cnt++;
    if (mem_wr && mem_ready) begin
      wr_acc_cnt++;
      wlog_addr.push_back(mem_addr);
      wlog_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    st_req  = 1'b1;
    st_op   = op;
    st_addr = addr;
    st_data = data;
  endtask

  // Read-modify-write store with configurable read latency and write backpressure.
  task automatic rmw(input string tag, input logic [1:0] op, input logic [31:0] addr,
                     input logic [31:0] data, input logic [31:0] rdata,
                     input logic [31:0] exp, input int rv_dly, input int rdy_dly);
    int rd0;
    int dn0;
    logic [31:0] waddr;
    waddr = {addr[31:2], 2'b00};
    @(negedge clk);
    rd0 = rd_cnt;
    dn0 = done_cnt;
    drive_req(op, addr, data);
    mem_ready = 1'b0;
    #1 check({tag, " idle_busy"}, {31'd0, st_busy}, 32'd0);
    @(negedge clk);
    st_req = 1'b0;
    #1;
    check({tag, " rd"}, {31'd0, mem_rd}, 32'd1);
    check({tag, " rd_addr"}, mem_addr, waddr);
    check({tag, " rd_no_wr"}, {31'd0, mem_wr}, 32'd0);
    mem_rdata = 32'hA5A5_5A5A;
    for (int i = 0; i < rv_dly; i++) begin
      @(negedge clk);
      #1;
      check({tag, " wait_busy"}, {31'd0, st_busy}, 32'd1);
      check({tag, " wait_quiet"}, {30'd0, mem_rd, mem_wr}, 32'd0);
    end
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    for (int i = 0; i < rdy_dly; i++) begin
      mem_ready = 1'b0;
      #1;
      check({tag, " hold_wr"}, {31'd0, mem_wr}, 32'd1);
      check({tag, " hold_wdata"}, mem_wdata, exp);
      check({tag, " hold_no_done"}, {31'd0, st_done}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check({tag, " wr"}, {31'd0, mem_wr}, 32'd1);
    check({tag, " wr_addr"}, mem_addr, waddr);
    check({tag, " wdata"}, mem_wdata, exp);
    check({tag, " done"}, {31'd0, st_done}, 32'd1);
    @(negedge clk);
    #1;
    check({tag, " back_idle"}, {31'd0, st_busy}, 32'd0);
    check({tag, " one_rd"}, rd_cnt - rd0, 32'd1);
    check({tag, " one_done"}, done_cnt - dn0, 32'd1);
  endtask

  // Rejected request: error pulse next cycle, no memory activity, stays idle.
  task automatic err_case(input string tag, input logic [1:0] op, input logic [31:0] addr);
    int rd0;
    int wr0;
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_acc_cnt;
    drive_req(op, addr, 32'h1234_5678);
    mem_ready = 1'b1;
    #1 check({tag, " err_early"}, {31'd0, st_err}, 32'd0);
    @(negedge clk);
    st_req = 1'b0;
    #1;
    check({tag, " err"}, {31'd0, st_err}, 32'd1);
    check({tag, " err_idle"}, {31'd0, st_busy}, 32'd0);
    @(negedge clk);
    #1;
    check({tag, " err_pulse"}, {31'd0, st_err}, 32'd0);
    check({tag, " err_no_mem"}, (rd_cnt - rd0) + (wr_acc_cnt - wr0), 32'd0);
  endtask

  initial begin
    int dn0;
    int wr0;
    rst = 1'b1;
    st_req = 1'b0; st_op = SB; st_addr = '0; st_data = '0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst busy", {31'd0, st_busy}, 32'd0);
    check("rst strobes", {27'd0, st_done, st_err, mem_rd, mem_wr, 1'b0}, 32'd0);
    check("rst addr", mem_addr, 32'd0);
    check("rst wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned word store: direct write, no read
    @(negedge clk);
    dn0 = rd_cnt;
    drive_req(SW, 32'h100, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    @(negedge clk);
    st_req = 1'b0;
    #1;
    check("sw wr", {31'd0, mem_wr}, 32'd1);
    check("sw addr", mem_addr, 32'h100);
    check("sw wdata", mem_wdata, 32'hDEAD_BEEF);
    check("sw done", {31'd0, st_done}, 32'd1);
    @(negedge clk);
    #1;
    check("sw idle", {31'd0, st_busy}, 32'd0);
    check("sw no_rd", rd_cnt - dn0, 32'd0);

    // Byte/halfword merges into 0x11223344
    rmw("sb203", SB, 32'h203, 32'h0000_00AA, 32'h1122_3344, 32'hAA22_3344, 0, 0);
    rmw("sh302", SH, 32'h302, 32'h0000_BEEF, 32'h1122_3344, 32'hBEEF_3344, 0, 0);
    rmw("sb200", SB, 32'h200, 32'h0000_0055, 32'h1122_3344, 32'h1122_3355, 0, 0);
    rmw("sb201", SB, 32'h201, 32'hFFFF_FF77, 32'h1122_3344, 32'h1122_7744, 0, 0);
    rmw("sh300", SH, 32'h300, 32'hCAFE_BEEF, 32'h1122_3344, 32'h1122_BEEF, 0, 0);

    // Errors: misaligned sh, misaligned sw, illegal op
    err_case("sh301", SH, 32'h301);
    err_case("sw102", SW, 32'h102);
    err_case("op11", IL, 32'h400);

    // Slow memory: read data 4 cycles late, write held 3 cycles
    rmw("sb_slow", SB, 32'h502, 32'h0000_0099, 32'h8877_6655, 32'h8899_6655, 4, 3);

    // Reset while waiting for read data, then a late rvalid/ready
    @(negedge clk);
    dn0 = done_cnt;
    wr0 = wr_acc_cnt;
    drive_req(SB, 32'h603, 32'h0000_0011);
    mem_ready = 1'b0;
    @(negedge clk);
    st_req = 1'b0;
    @(negedge clk);
    #1 check("rstw in_wait", {31'd0, st_busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    #1;
    check("rstw idle", {31'd0, st_busy}, 32'd0);
    check("rstw addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_ready  = 1'b1;
    #1 check("rstw still_idle", {31'd0, st_busy}, 32'd0);
    @(negedge clk);
    #1;
    check("rstw no_wr", wr_acc_cnt - wr0, 32'd0);
    check("rstw no_done", done_cnt - dn0, 32'd0);

    // Back-to-back word stores, second request held while busy
    @(negedge clk);
    dn0 = done_cnt;
    wr0 = wr_acc_cnt;
    drive_req(SW, 32'h700, 32'h0A0A_0A0A);
    mem_ready = 1'b0;
    @(negedge clk);
    drive_req(SW, 32'h704, 32'h0B0B_0B0B);
    #1;
    check("b2b first_wr", {31'd0, mem_wr}, 32'd1);
    check("b2b first_hold", mem_wdata, 32'h0A0A_0A0A);
    @(negedge clk);
    mem_ready = 1'b1;
    #1 check("b2b first_done", {31'd0, st_done}, 32'd1);
    @(negedge clk);
    #1 check("b2b gap_idle", {31'd0, st_busy}, 32'd0);
    @(negedge clk);
    st_req = 1'b0;
    #1;
    check("b2b second_addr", mem_addr, 32'h704);
    check("b2b second_done", {31'd0, st_done}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("b2b writes", wr_acc_cnt - wr0, 32'd2);
    check("b2b dones", done_cnt - dn0, 32'd2);
    check("b2b order_a", wlog_addr[wlog_addr.size() - 2], 32'h700);
    check("b2b order_d", wlog_data[wlog_data.size() - 2], 32'h0A0A_0A0A);
    check("b2b last_d", wlog_data[wlog_data.size() - 1], 32'h0B0B_0B0B);

    check("rd_wr overlap", overlap_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
